// File: rtl/d_flipflop.sv
// rtl/d_flipflop.sv - width-parameterised D-type register with synchronous active-low reset
//
// Purpose:
//   Edge-triggered storage register. It captures D on every rising edge of clk
//   and holds that value on Q until the next rising edge. It has no enable, no
//   set input and no asynchronous path. The default 1-bit instance is the plain
//   D flip-flop.
//
// Parameters:
//   WIDTH        bit width of D and Q
//   RESET_VALUE  value loaded into Q at a rising edge that samples reset == 0
//
// Ports:
//   clk    clock; Q changes only on its rising edge
//   reset  synchronous reset, active-low, sampled on the rising edge of clk
//   D      data input, sampled on the rising edge of clk
//   Q      registered output, driven straight from the storage register

module d_flipflop #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Reset takes priority over D at the same edge. Releasing reset needs no
    // recovery cycle: the first edge that samples reset == 1 captures D.
    // There is no power-up value, so Q stays unknown until the first edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            Q <= RESET_VALUE;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: tb/tb_d_flipflop.sv
// tb/tb_d_flipflop.sv - directed self-checking bench for d_flipflop

module tb_d_flipflop;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1;
    logic       q1;
    logic       reset8;
    logic [7:0] d8;
    logic [7:0] q8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    d_flipflop u_dff1 (
        .clk   (clk),
        .reset (reset),
        .D     (d1),
        .Q     (q1)
    );

    d_flipflop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dff8 (
        .clk   (clk),
        .reset (reset8),
        .D     (d8),
        .Q     (q8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rise;
        @(posedge clk);
        #1;
    endtask

    task automatic fall;
        @(negedge clk);
        #1;
    endtask

    logic [3:0] track_vec;

    initial begin
        track_vec = 4'b1001;
        reset  = 1'b0;
        d1     = 1'bx;
        reset8 = 1'b0;
        d8     = 8'h00;

        // reset capture
        rise();
        check("rst_capture", {7'd0, q1}, 8'h00);
        d1 = 1'b1;
        #2;
        check("rst_hold_d_change", {7'd0, q1}, 8'h00);

        // release and capture
        fall();
        reset = 1'b1;
        d1    = 1'b1;
        #1;
        check("release_no_edge", {7'd0, q1}, 8'h00);
        rise();
        check("release_capture", {7'd0, q1}, 8'h01);
        fall();
        check("falling_no_effect", {7'd0, q1}, 8'h01);
        rise();
        check("second_capture", {7'd0, q1}, 8'h01);

        // data tracking with glitches between edges
        for (int i = 3; i >= 0; i--) begin
            fall();
            d1 = track_vec[i];
            #1 d1 = ~track_vec[i];
            #1 d1 = track_vec[i];
            rise();
            check($sformatf("track_%0d", 3 - i), {7'd0, q1}, {7'd0, track_vec[i]});
            d1 = ~track_vec[i];
            #1;
            check($sformatf("track_hold_%0d", 3 - i), {7'd0, q1}, {7'd0, track_vec[i]});
        end

        // synchronous reset assert and release timing (q1 == 1 here)
        fall();
        reset = 1'b0;
        d1    = 1'b1;
        #1;
        check("rst_assert_midcycle", {7'd0, q1}, 8'h01);
        rise();
        check("rst_assert_edge", {7'd0, q1}, 8'h00);
        fall();
        reset = 1'b1;
        d1    = 1'b1;
        #1;
        check("rst_release_midcycle", {7'd0, q1}, 8'h00);
        rise();
        check("rst_release_edge", {7'd0, q1}, 8'h01);

        // reset priority over D for three edges
        fall();
        reset = 1'b0;
        d1    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rise();
            check($sformatf("rst_priority_%0d", i), {7'd0, q1}, 8'h00);
        end

        // 8-bit instance with non-zero reset value
        fall();
        d8 = 8'h3C;
        rise();
        check("w8_reset", q8, 8'hA5);
        fall();
        reset8 = 1'b1;
        d8     = 8'h3C;
        rise();
        check("w8_capture", q8, 8'h3C);
        d8 = 8'hFF;
        #2;
        check("w8_hold_high", q8, 8'h3C);
        fall();
        check("w8_hold_low", q8, 8'h3C);
        rise();
        check("w8_capture_ff", q8, 8'hFF);
        fall();
        reset8 = 1'b0;
        d8     = 8'h00;
        rise();
        check("w8_rereset", q8, 8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
